// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one 8-bit MAC TX AXI-stream port.
// A stall watchdog aborts a frame whose granted source goes idle mid-frame: it
// emits a single bad terminating beat to the MAC, then drains the rest of the frame.
module eth_tx_frame_arbiter #(
    parameter int unsigned S_COUNT = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
    parameter int unsigned IW      = $clog2(S_COUNT)
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst,
    input  logic [S_COUNT*8-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]   s_axis_tvalid,
    output logic [S_COUNT-1:0]   s_axis_tready,
    input  logic [S_COUNT-1:0]   s_axis_tlast,
    input  logic [S_COUNT-1:0]   s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic [S_COUNT-1:0]   src_enable,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_index,
    output logic                 frame_abort
);

    typedef enum logic [1:0] {StIdle, StActive, StAbort, StDrain} state_e;

    // Count value at which one more idle cycle fires the watchdog.
    localparam logic [CW-1:0] CntLast = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic [S_COUNT-1:0] req;
    logic               arb_found;
    logic [IW-1:0]      arb_pick;
    logic [31:0]        arb_idx;

    logic [7:0] sel_data;
    logic       sel_valid;
    logic       sel_last;
    logic       sel_user;

    // Granted source's stream signals.
    always_comb begin
        sel_data  = s_axis_tdata[{grant_q, 3'b000} +: 8];
        sel_valid = s_axis_tvalid[grant_q];
        sel_last  = s_axis_tlast[grant_q];
        sel_user  = s_axis_tuser[grant_q];
    end

    // Round-robin pick: first requester scanning upward from last_q+1 with wrap.
    always_comb begin
        req       = s_axis_tvalid & src_enable;
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = '0;
        for (int unsigned k = 1; k <= S_COUNT; k++) begin
            arb_idx = (32'(last_q) + k) % S_COUNT;
            if (!arb_found && req[arb_idx[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx[IW-1:0];
            end
        end
    end

    // Next-state, watchdog and stream output decode.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        abort_d       = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (arb_found) begin
                    grant_d = arb_pick;
                    state_d = StActive;
                end
            end
            StActive: begin
                m_axis_tdata           = sel_data;
                m_axis_tvalid          = sel_valid;
                m_axis_tlast           = sel_last;
                m_axis_tuser           = sel_user;
                s_axis_tready[grant_q] = m_axis_tready;
                if (sel_valid) begin
                    // Valid source (even under MAC backpressure) is never a stall.
                    cnt_d = '0;
                    if (m_axis_tready && sel_last) begin
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == CntLast) begin
                        abort_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StAbort;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StAbort: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                s_axis_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset leaves the pointer at S_COUNT-1 so source 0 wins first.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IW'(S_COUNT - 1);
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign grant_valid = (state_q != StIdle);
    assign grant_index = grant_q;
    assign frame_abort = abort_q;

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter in the MAC TX clock domain; shares one 8-bit MAC TX AXI-stream input between S_COUNT 8-bit frame sources.
- Sits between per-source TX FIFO outputs and the MAC TX stream port.
- A stall watchdog prevents a stalled source from underflowing the MAC: it terminates the frame as bad, then drains the rest of it.

Parameters:
- S_COUNT, 4, number of source ports (2..16).
- TIMEOUT, 16, consecutive granted-source idle cycles mid-frame before abort; 0 disables the watchdog.
- CW, $clog2(TIMEOUT+1) (minimum 1), watchdog counter width.
- IW, $clog2(S_COUNT), grant index width.

Ports:
- tx_clk  in  1  TX clock.
- tx_rst  in  1  Reset: asynchronous, active-high.
- s_axis_tdata  in  S_COUNT*8  Source data; source i uses bits [8i+7:8i].
- s_axis_tvalid  in  S_COUNT  Per-source valid.
- s_axis_tready  out  S_COUNT  Per-source ready.
- s_axis_tlast  in  S_COUNT  Per-source last.
- s_axis_tuser  in  S_COUNT  Per-source bad-frame flag.
- m_axis_tdata  out  8  To MAC.
- m_axis_tvalid  out  1  To MAC.
- m_axis_tready  in  1  From MAC.
- m_axis_tlast  out  1  To MAC.
- m_axis_tuser  out  1  To MAC; 1 = bad frame.
- src_enable  in  S_COUNT  Per-source arbitration enable, sampled only in IDLE.
- grant_valid  out  1  High in ACTIVE, ABORT and DRAIN.
- grant_index  out  IW  Currently or last granted source.
- frame_abort  out  1  One-cycle pulse when the watchdog fires.

Behaviour:
- Reset: state=IDLE, grant_valid=0, grant_index=0, last pointer=S_COUNT-1 (source 0 wins first), watchdog count=0, frame_abort=0, all s_axis_tready=0, m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0.
- Reset asserted mid-frame: immediate return to reset state. The partial frame is abandoned; the MAC's own underflow handling applies.
- IDLE:
  - req = s_axis_tvalid & src_enable.
  - If req != 0: pick the first set bit scanning from last+1 upward with wrap, register it into grant_index, assert grant_valid, go to ACTIVE.
  - No data passes in IDLE. Arbitration costs exactly 1 cycle, so the first beat appears on m_axis the cycle after request is seen.
- ACTIVE (g = grant_index):
  - Combinational pass-through: m_axis_tdata/tvalid/tlast/tuser = source g; s_axis_tready[g] = m_axis_tready; all other tready = 0.
  - Beat accepted with tlast: last<=g, grant_valid<=0, go to IDLE. Back-to-back frames therefore have 1 idle cycle between them.
  - src_enable changes mid-frame have no effect until frame end.
- Watchdog (ACTIVE only, TIMEOUT>0):
  - Count increments each cycle s_axis_tvalid[g]=0; clears to 0 on any cycle s_axis_tvalid[g]=1.
  - Counter clears on entering ACTIVE; it does not run when m_axis_tready=0 while the source is valid (MAC backpressure is not a stall).
  - When count reaches TIMEOUT (in the cycle it would reach it): frame_abort=1 for one cycle, go to ABORT.
- ABORT:
  - m_axis_tvalid=1, tlast=1, tuser=1, tdata=8'h00; all s_axis_tready=0.
  - Hold until m_axis_tready=1, then go to DRAIN.
- DRAIN:
  - m_axis_tvalid=0; s_axis_tready[g]=1.
  - Discard source-g beats until a beat with tlast is accepted; then last<=g, grant_valid<=0, go to IDLE.
- Simultaneous source valid and timeout threshold in the same cycle: valid wins; count clears, no abort.
- Single-beat frame (tlast on first beat): ACTIVE for one accepted beat, then IDLE.
- All sources disabled or idle: stay in IDLE, m_axis_tvalid=0.
- No combinational path from m_axis_tready to m_axis_tvalid.

Test Plan:
- Reset, then sources 0 and 2 each present a 3-beat frame (0x11,0x12,0x13 / 0x21,0x22,0x23), MAC ready always → m_axis carries source 0 frame, 1 idle cycle, source 2 frame; grant_index 0 then 2; tuser=0.
- All 4 sources continuously valid with 2-beat frames → grant order 0,1,2,3,0; each frame intact; no interleaving.
- src_enable=4'b1101, sources 1 and 3 valid → only source 3 granted; clear enable[3] mid-frame → frame still completes.
- TIMEOUT=16, source 1 sends 2 beats then holds tvalid=0 for 16 cycles, then sends 3 more beats ending in tlast → frame_abort pulses once; m_axis emits 0x00 with tlast=1, tuser=1; the 3 later beats are consumed with m_axis_tvalid=0; then IDLE.
- MAC holds m_axis_tready=0 for 40 cycles with source valid mid-frame → no abort; data resumes unchanged.
- Assert tx_rst for 1 cycle mid-frame on source 2 → all outputs 0 immediately; next arbitration starts from source 0.
